sprite_blitter: RTL and testbench

Parametrised sprite blitter for the 160x120 VGA framebuffer path; successor to the fixed 8x8 sprite drawer. Accepts draw commands (anchor, sprite id, mode, fill colour) over a valid/ready handshake and holds one command in a buffer while another is in flight. It streams pixels from an external synchronous sprite ROM to the vga_adapter plot port. It adds transparency keying, screen-edge clipping, a solid-fill/erase mode and back-to-back commands with no bubble.

---
 rtl/sprite_blitter.sv | 159 +++++++++++++++
 tb/tb_sprite_blitter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: buffered draw/fill commands, streams sprite ROM pixels to the
// framebuffer plot port with transparency keying and screen-edge clipping.
module sprite_blitter #(
    parameter int unsigned SPR_W_LOG2 = 3,
    parameter int unsigned SPR_H_LOG2 = 3,
    parameter int unsigned ID_W       = 3,
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = 12'hF0F
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [X_W-1:0]                          cmd_x,
    input  logic [Y_W-1:0]                          cmd_y,
    input  logic [ID_W-1:0]                         cmd_id,
    input  logic                                    cmd_fill,
    input  logic [COLOR_W-1:0]                      cmd_colour,
    output logic [ID_W+SPR_H_LOG2+SPR_W_LOG2-1:0]   rom_addr,
    input  logic [COLOR_W-1:0]                      rom_data,
    output logic                                    plot,
    output logic [X_W-1:0]                          x,
    output logic [Y_W-1:0]                          y,
    output logic [COLOR_W-1:0]                      colour,
    output logic                                    busy,
    output logic                                    done
);
    localparam int unsigned P_W = SPR_W_LOG2 + SPR_H_LOG2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;

    logic               buf_full_q;
    logic [X_W-1:0]     buf_x_q;
    logic [Y_W-1:0]     buf_y_q;
    logic [ID_W-1:0]    buf_id_q;
    logic               buf_fill_q;
    logic [COLOR_W-1:0] buf_col_q;

    logic [X_W-1:0]     ax_q;
    logic [Y_W-1:0]     ay_q;
    logic [ID_W-1:0]    id_q;
    logic               fill_q;
    logic [COLOR_W-1:0] col_q;
    logic [P_W-1:0]     p_q, p_d;

    logic               vld_q, last_q, clip_q, pfill_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [COLOR_W-1:0] pcol_q;

    logic                  accept, load;
    logic [SPR_W_LOG2-1:0] px;
    logic [SPR_H_LOG2-1:0] py;
    logic [X_W:0]          sum_x;
    logic [Y_W:0]          sum_y;
    logic                  clip;

    assign accept = cmd_valid & ~buf_full_q;
    assign px     = p_q[SPR_W_LOG2-1:0];
    assign py     = p_q[P_W-1:SPR_W_LOG2];
    // One extra bit so an anchor near the top of the range clips instead of wrapping.
    assign sum_x  = {1'b0, ax_q} + (X_W+1)'(px);
    assign sum_y  = {1'b0, ay_q} + (Y_W+1)'(py);
    assign clip   = (sum_x >= (X_W+1)'(SCREEN_W)) | (sum_y >= (Y_W+1)'(SCREEN_H));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        p_d     = p_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (p_q == '1) begin
                    if (buf_full_q) load = 1'b1;
                    else            state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (load) p_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            p_q        <= '0;
            buf_full_q <= 1'b0;
            buf_x_q    <= '0;
            buf_y_q    <= '0;
            buf_id_q   <= '0;
            buf_fill_q <= 1'b0;
            buf_col_q  <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            id_q       <= '0;
            fill_q     <= 1'b0;
            col_q      <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            clip_q     <= 1'b0;
            pfill_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            pcol_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            if (accept) begin
                buf_full_q <= 1'b1;
                buf_x_q    <= cmd_x;
                buf_y_q    <= cmd_y;
                buf_id_q   <= cmd_id;
                buf_fill_q <= cmd_fill;
                buf_col_q  <= cmd_colour;
            end else if (load) begin
                buf_full_q <= 1'b0;
            end
            if (load) begin
                ax_q   <= buf_x_q;
                ay_q   <= buf_y_q;
                id_q   <= buf_id_q;
                fill_q <= buf_fill_q;
                col_q  <= buf_col_q;
            end
            vld_q  <= (state_q == StRun);
            last_q <= (p_q == '1);
            if (state_q == StRun) begin
                x_q     <= sum_x[X_W-1:0];
                y_q     <= sum_y[Y_W-1:0];
                clip_q  <= clip;
                pfill_q <= fill_q;
                pcol_q  <= col_q;
            end
        end
    end

    assign cmd_ready = ~buf_full_q;
    assign rom_addr  = (state_q == StRun) ? {id_q, p_q} : '0;
    // rom_data lines up with the registered pixel stage, so keying is done here.
    assign plot      = vld_q & ~clip_q & (pfill_q | (rom_data != TRANSP_KEY));
    assign colour    = vld_q ? (pfill_q ? pcol_q : rom_data) : '0;
    assign x         = x_q;
    assign y         = y_q;
    assign done      = vld_q & last_q;
    assign busy      = (state_q != StIdle) | vld_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: cycle-indexed expectation tables built from
// the command timing rules, checked every cycle, plus hand-computed literal checks.
module tb_sprite_blitter;
    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0;
    logic [6:0]  cmd_y = '0;
    logic [2:0]  cmd_id = '0;
    logic        cmd_fill = 1'b0;
    logic [11:0] cmd_colour = '0;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] colour;
    logic        busy;
    logic        done;

    sprite_blitter dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_id(cmd_id), .cmd_fill(cmd_fill),
        .cmd_colour(cmd_colour), .rom_addr(rom_addr), .rom_data(rom_data),
        .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [512];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit        e_plot [MAXC];
    bit        e_done [MAXC];
    bit        e_busy [MAXC];
    bit        e_full [MAXC];
    bit        e_rav  [MAXC];
    bit        e_rst  [MAXC];
    bit [7:0]  e_x    [MAXC];
    bit [6:0]  e_y    [MAXC];
    bit [11:0] e_col  [MAXC];
    bit [8:0]  e_ra   [MAXC];
    int        f_free = -1000;

    int plot_cnt = 0;
    int busy_cnt = 0;
    int q_t[$];
    int q_x[$];
    int q_y[$];
    int q_c[$];
    int done_t[$];
    int done_x, done_y;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset(int t);
        for (int i = t; i < MAXC; i++) begin
            e_plot[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_full[i] = 0;
            e_rav[i] = 0; e_rst[i] = 0;
        end
        e_rst[t] = 1;
        f_free = -1000;
    endfunction

    // A command accepted at edge t: first slot two edges later, or right behind the
    // previous command if it was waiting in the buffer before that one's last address.
    function automatic void add_cmd(int t, int ax, int ay, int id, bit fl, int col);
        int s, sx, sy, rc, c;
        if (t <= f_free - 2) s = f_free;
        else s = (t + 2 > f_free + 3) ? t + 2 : f_free + 3;
        for (int i = t; i <= s - 2; i++) if (i < MAXC) e_full[i] = 1;
        for (int i = s - 1; i <= s + 63; i++) if (i < MAXC) e_busy[i] = 1;
        for (int k = 0; k < 64; k++) begin
            sx = ax + k % 8;
            sy = ay + k / 8;
            rc = int'(rom[id * 64 + k]);
            c  = s + k;
            if (c < MAXC) begin
                e_plot[c] = (sx < 160) && (sy < 120) && (fl || rc != 12'hF0F);
                e_x[c]    = 8'(sx % 256);
                e_y[c]    = 7'(sy % 128);
                e_col[c]  = fl ? 12'(col) : 12'(rc);
                e_done[c] = (k == 63);
            end
            if (c - 1 < MAXC) begin
                e_rav[c-1] = 1;
                e_ra[c-1]  = 9'(id * 64 + k);
            end
        end
        f_free = s + 64;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (reset) model_reset(cyc);
        else if (cmd_valid && cmd_ready)
            add_cmd(cyc, int'(cmd_x), int'(cmd_y), int'(cmd_id), cmd_fill, int'(cmd_colour));
    end

    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc < MAXC) begin
            chk("plot", 32'(plot), 32'(e_plot[cyc]));
            chk("done", 32'(done), 32'(e_done[cyc]));
            chk("busy", 32'(busy), 32'(e_busy[cyc]));
            chk("cmd_ready", 32'(cmd_ready), 32'(!e_full[cyc]));
            if (e_plot[cyc]) begin
                chk("x", 32'(x), 32'(e_x[cyc]));
                chk("y", 32'(y), 32'(e_y[cyc]));
                chk("colour", 32'(colour), 32'(e_col[cyc]));
            end
            if (e_rav[cyc]) chk("rom_addr", 32'(rom_addr), 32'(e_ra[cyc]));
            if (e_rst[cyc]) begin
                chk("rst_rom_addr", 32'(rom_addr), 32'd0);
                chk("rst_xy", {x, y}, 32'd0);
                chk("rst_colour", 32'(colour), 32'd0);
            end
            if (busy) busy_cnt++;
            if (plot) begin
                plot_cnt++;
                q_t.push_back(cyc); q_x.push_back(int'(x));
                q_y.push_back(int'(y)); q_c.push_back(int'(colour));
            end
            if (done) begin
                done_t.push_back(cyc); done_x = int'(x); done_y = int'(y);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        plot_cnt = 0; busy_cnt = 0;
        q_t.delete(); q_x.delete(); q_y.delete(); q_c.delete(); done_t.delete();
        done_x = -1; done_y = -1;
    endtask

    task automatic send(input int sx, input int sy, input int id, input bit fl,
                        input int col, output int acc);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_x = 8'(sx); cmd_y = 7'(sy); cmd_id = 3'(id);
        cmd_fill = fl; cmd_colour = 12'(col);
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 500), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !cmd_ready) && n < 500);
        chk("idle_timeout", 32'(n < 500), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    int t1, t2, diag;

    initial begin
        for (int a = 0; a < 512; a++) rom[a] = 12'(((a / 8) % 8) * 16 + a % 8);
        for (int i = 0; i < 8; i++) rom[5 * 64 + i * 9] = 12'hF0F;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain draw
        clear_stats();
        send(10, 20, 2, 0, 0, t1);
        wait_idle();
        chk("draw_plots", 32'(plot_cnt), 32'd64);
        chk("draw_latency", 32'(q_t[0] - t1), 32'd2);
        chk("draw_span", 32'(q_t[63] - q_t[0]), 32'd63);
        chk("draw_px9", {q_x[9], q_y[9]}, {32'd11, 32'd21});
        chk("draw_col9", 32'(q_c[9]), 32'h011);
        chk("draw_done_xy", {done_x, done_y}, {32'd17, 32'd27});
        chk("draw_done_cnt", 32'(done_t.size()), 32'd1);

        // Transparency on the diagonal
        clear_stats();
        send(10, 20, 5, 0, 0, t1);
        wait_idle();
        diag = 0;
        foreach (q_x[i]) if (q_x[i] - 10 == q_y[i] - 20) diag++;
        chk("transp_plots", 32'(plot_cnt), 32'd56);
        chk("transp_diag", 32'(diag), 32'd0);
        chk("transp_done_cnt", 32'(done_t.size()), 32'd1);

        // Clipping at the bottom-right corner
        clear_stats();
        send(156, 116, 2, 0, 0, t1);
        wait_idle();
        chk("clip_plots", 32'(plot_cnt), 32'd16);

        // x sum carries out of 8 bits
        clear_stats();
        send(255, 0, 2, 0, 0, t1);
        wait_idle();
        chk("ovf_plots", 32'(plot_cnt), 32'd0);
        chk("ovf_busy", 32'(busy_cnt), 32'd65);
        chk("ovf_done_cnt", 32'(done_t.size()), 32'd1);

        // Back-to-back draw then fill
        clear_stats();
        send(0, 0, 2, 0, 0, t1);
        send(40, 40, 0, 1, 12'h00F, t2);
        chk("b2b_ready_low", 32'(cmd_ready), 32'd0);
        wait_idle();
        chk("b2b_plots", 32'(plot_cnt), 32'd128);
        chk("b2b_span", 32'(q_t[127] - q_t[0]), 32'd127);
        chk("b2b_col64", 32'(q_c[64]), 32'h00F);
        chk("b2b_col127", 32'(q_c[127]), 32'h00F);
        chk("b2b_done_cnt", 32'(done_t.size()), 32'd2);
        if (done_t.size() == 2) chk("b2b_done_gap", 32'(done_t[1] - done_t[0]), 32'd64);

        // Reset mid-command with a buffered command
        clear_stats();
        send(50, 50, 2, 0, 0, t1);
        send(60, 60, 3, 0, 0, t2);
        t1 = 0;
        while (plot_cnt < 30 && t1 < 200) begin
            @(negedge clk);
            t1++;
        end
        chk("rst_reach_px30", 32'(t1 < 200), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_stats();
        repeat (80) @(negedge clk);
        chk("post_rst_plots", 32'(plot_cnt), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        send(5, 5, 2, 0, 0, t1);
        wait_idle();
        chk("post_rst_draw", 32'(plot_cnt), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
